// File: rtl/frame_scan_controller.sv
// Raster-order frame scanner: one read per pixel, one 3x3 window
// centre handed to the Sobel stage after each completed neighbourhood.
module frame_scan_controller #(
  parameter int DIM_BITS  = 10,
  parameter int ADDR_BITS = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [DIM_BITS-1:0]  img_width,
  input  logic [DIM_BITS-1:0]  img_height,
  input  logic [ADDR_BITS-1:0] base_addr,
  output logic                 rd_req,
  output logic [ADDR_BITS-1:0] rd_addr,
  input  logic                 rd_ack,
  output logic                 win_valid,
  output logic [DIM_BITS-1:0]  win_row,
  output logic [DIM_BITS-1:0]  win_col,
  input  logic                 win_ready,
  output logic                 busy,
  output logic                 done,
  output logic                 cfg_err
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WIN,
    DONE
  } state_t;

  localparam logic [DIM_BITS-1:0]  D_ONE = DIM_BITS'(1);
  localparam logic [DIM_BITS-1:0]  D_TWO = DIM_BITS'(2);
  localparam logic [DIM_BITS-1:0]  D_MIN = DIM_BITS'(3);
  localparam logic [ADDR_BITS-1:0] A_ONE = ADDR_BITS'(1);

  state_t              state;
  logic [DIM_BITS-1:0] w_q;
  logic [DIM_BITS-1:0] h_q;
  logic [DIM_BITS-1:0] row;
  logic [DIM_BITS-1:0] col;
  logic                last;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      w_q       <= '0;
      h_q       <= '0;
      row       <= '0;
      col       <= '0;
      last      <= 1'b0;
      rd_req    <= 1'b0;
      rd_addr   <= '0;
      win_valid <= 1'b0;
      win_row   <= '0;
      win_col   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      done    <= 1'b0;
      cfg_err <= 1'b0;
      if (abort && state != IDLE) begin
        state     <= IDLE;
        rd_req    <= 1'b0;
        win_valid <= 1'b0;
        busy      <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (start && !abort) begin
              if (img_width >= D_MIN && img_height >= D_MIN) begin
                state   <= READ;
                w_q     <= img_width;
                h_q     <= img_height;
                row     <= '0;
                col     <= '0;
                rd_addr <= base_addr;
                rd_req  <= 1'b1;
                busy    <= 1'b1;
              end else begin
                cfg_err <= 1'b1;
              end
            end
          end
          READ: begin
            if (rd_ack) begin
              if (col == w_q - D_ONE) begin
                col <= '0;
                row <= row + D_ONE;
              end else begin
                col <= col + D_ONE;
              end
              rd_addr <= rd_addr + A_ONE;
              // pixel (row,col) closes the window centred one up-left
              if (row >= D_TWO && col >= D_TWO) begin
                state     <= WIN;
                rd_req    <= 1'b0;
                win_valid <= 1'b1;
                win_row   <= row - D_ONE;
                win_col   <= col - D_ONE;
                last      <= (row == h_q - D_ONE) &&
                             (col == w_q - D_ONE);
              end
            end
          end
          WIN: begin
            if (win_ready) begin
              win_valid <= 1'b0;
              if (last) begin
                state <= DONE;
                done  <= 1'b1;
              end else begin
                state  <= READ;
                rd_req <= 1'b1;
              end
            end
          end
          DONE: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
